bilinear_interp_pipe: RTL and testbench

Pipelined, parametrised bilinear interpolation datapath that blends four neighbouring RAMFIFO pixels using fractional weights. It supersedes the single-cycle combinational interpolator inside the scaler calculation stage. It adds:
- an arbitrary channel count and channel width
- round-to-nearest with saturation
- a nearest-neighbour mode
- edge replication
- valid/ready backpressure with HS/VS sideband kept aligned to the data

It sits between the address/coefficient generator and the output-timing stage.

---
 rtl/bilinear_interp_pipe_if.sv | 23 ++
 rtl/bilinear_interp_pipe.sv | 74 +++++++
 tb/tb_bilinear_interp_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bilinear_interp_pipe_if.sv
// bilinear_interp_pipe_if: input beat (four neighbours, weights, sideband) and output pixel stream with valid/ready
interface bilinear_interp_pipe_if #(
  parameter int NUM_CH = 3,
  parameter int CH_WIDTH = 8,
  parameter int FRAC_WIDTH = 6
);
  localparam int DATA_WIDTH = NUM_CH * CH_WIDTH;
  logic in_valid, in_ready;
  logic [DATA_WIDTH-1:0] d00, d01, d10, d11;
  logic [FRAC_WIDTH-1:0] uF, vF;
  logic x_edge, y_edge, mode, in_hs, in_vs;
  logic out_valid, out_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic out_hs, out_vs;
  modport master(
    output in_valid, d00, d01, d10, d11, uF, vF, x_edge, y_edge, mode, in_hs, in_vs, out_ready,
    input in_ready, out_valid, dout, out_hs, out_vs
  );
  modport slave(
    input in_valid, d00, d01, d10, d11, uF, vF, x_edge, y_edge, mode, in_hs, in_vs, out_ready,
    output in_ready, out_valid, dout, out_hs, out_vs
  );
endinterface

// File: rtl/bilinear_interp_pipe.sv
// bilinear_interp_pipe: 3-stage bilinear/nearest pixel blend with edge replication, rounding, saturation and global-stall backpressure
module bilinear_interp_pipe #(
  parameter int NUM_CH = 3,
  parameter int CH_WIDTH = 8,
  parameter int FRAC_WIDTH = 6
) (
  input logic clk,
  input logic rst,
  bilinear_interp_pipe_if.slave bus
);
  localparam int DATA_WIDTH = NUM_CH * CH_WIDTH;
  localparam int HW = CH_WIDTH + FRAC_WIDTH + 1;
  localparam int SW = CH_WIDTH + 2 * FRAC_WIDTH + 1;
  localparam logic [FRAC_WIDTH:0] ONE = (FRAC_WIDTH + 1)'(1) << FRAC_WIDTH;
  localparam logic [SW:0] HALF = (SW + 1)'(1) << (2 * FRAC_WIDTH - 1);
  localparam logic [SW:0] MAXV = (SW + 1)'({CH_WIDTH{1'b1}});

  logic en, v1, v2, v3, hs1, vs1, hs2, vs2, hs3, vs3;
  logic [DATA_WIDTH-1:0] p01, p10, p11, dout;
  logic [FRAC_WIDTH:0] uW, vW, vW1;
  logic [NUM_CH-1:0][HW-1:0] h0, h1;
  logic [NUM_CH-1:0][SW-1:0] s2;

  function automatic logic [HW-1:0] hMix(input logic [CH_WIDTH-1:0] a, b, input logic [FRAC_WIDTH:0] w);
    return HW'(a) * HW'(ONE - w) + HW'(b) * HW'(w);
  endfunction

  function automatic logic [SW-1:0] vMix(input logic [HW-1:0] a, b, input logic [FRAC_WIDTH:0] w);
    return SW'(a) * SW'(ONE - w) + SW'(b) * SW'(w);
  endfunction

  function automatic logic [CH_WIDTH-1:0] roundSat(input logic [SW-1:0] s);
    logic [SW:0] r;
    r = ({1'b0, s} + HALF) >> (2 * FRAC_WIDTH);
    return (r > MAXV) ? {CH_WIDTH{1'b1}} : r[CH_WIDTH-1:0];
  endfunction

  assign en = !v3 || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = v3;
  assign bus.dout = dout;
  assign bus.out_hs = hs3;
  assign bus.out_vs = vs3;

  // Nearest mode reuses the blend datapath with 0/ONE weights, so latency matches bilinear
  always_comb begin
    p01 = bus.x_edge ? bus.d00 : bus.d01;
    p10 = bus.y_edge ? bus.d00 : bus.d10;
    p11 = bus.y_edge ? p01 : bus.x_edge ? bus.d10 : bus.d11;
    uW = bus.mode ? (bus.uF[FRAC_WIDTH-1] ? ONE : '0) : {1'b0, bus.uF};
    vW = bus.mode ? (bus.vF[FRAC_WIDTH-1] ? ONE : '0) : {1'b0, bus.vF};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3, hs1, vs1, hs2, vs2, hs3, vs3} <= '0;
      dout <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      {hs1, vs1} <= {bus.in_hs, bus.in_vs};
      {hs2, vs2} <= {hs1, vs1};
      {hs3, vs3} <= {hs2, vs2};
      vW1 <= vW;
      for (int c = 0; c < NUM_CH; c++) begin
        h0[c] <= hMix(bus.d00[c*CH_WIDTH +: CH_WIDTH], p01[c*CH_WIDTH +: CH_WIDTH], uW);
        h1[c] <= hMix(p10[c*CH_WIDTH +: CH_WIDTH], p11[c*CH_WIDTH +: CH_WIDTH], uW);
        s2[c] <= vMix(h0[c], h1[c], vW1);
        dout[c*CH_WIDTH +: CH_WIDTH] <= roundSat(s2[c]);
      end
    end
  end
endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// tb_bilinear_interp_pipe: directed and randomized beats scored against an arithmetic model of the interpolator
module tb_bilinear_interp_pipe;
  localparam int NUM_CH = 3, CH_WIDTH = 8, FRAC_WIDTH = 6;

  typedef struct {
    logic [23:0] d00, d01, d10, d11;
    logic [5:0] u, v;
    logic xe, ye, mode, hs, vs;
  } beatT;

  logic clk = 0, rst = 1;
  int nChecks = 0, nFails = 0, nOut = 0;
  logic [25:0] q[$];
  logic stallPrev = 0;
  logic [25:0] prevOut;
  logic stopRnd;

  bilinear_interp_pipe_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) bus();
  bilinear_interp_pipe #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: pick or blend with plain integer arithmetic, result {hs, vs, pixel}
  function automatic logic [25:0] model(input beatT b);
    logic [23:0] a, bb, cc, dd, pix;
    int u, v, s, r;
    a = b.d00;
    bb = b.xe ? b.d00 : b.d01;
    cc = b.ye ? b.d00 : b.d10;
    dd = b.ye ? bb : (b.xe ? b.d10 : b.d11);
    u = int'(b.u);
    v = int'(b.v);
    if (b.mode) pix = (v >= 32) ? ((u >= 32) ? dd : cc) : ((u >= 32) ? bb : a);
    else begin
      pix = '0;
      for (int c = 0; c < 3; c++) begin
        s = (int'(a[c*8 +: 8]) * (64 - u) + int'(bb[c*8 +: 8]) * u) * (64 - v)
          + (int'(cc[c*8 +: 8]) * (64 - u) + int'(dd[c*8 +: 8]) * u) * v;
        r = (s + 2048) / 4096;
        if (r > 255) r = 255;
        pix[c*8 +: 8] = 8'(r);
      end
    end
    return {b.hs, b.vs, pix};
  endfunction

  function automatic beatT mk(input logic [23:0] d00, d01, d10, d11, input logic [5:0] u, v,
                              input logic xe, ye, mode);
    beatT b;
    b.d00 = d00; b.d01 = d01; b.d10 = d10; b.d11 = d11;
    b.u = u; b.v = v; b.xe = xe; b.ye = ye; b.mode = mode;
    b.hs = 1'($urandom_range(0, 1)); b.vs = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic beatT rndBeat();
    return mk(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom),
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
  endfunction

  task automatic sendBeat(input beatT b);
    logic acc;
    bus.d00 = b.d00; bus.d01 = b.d01; bus.d10 = b.d10; bus.d11 = b.d11;
    bus.uF = b.u; bus.vF = b.v; bus.x_edge = b.xe; bus.y_edge = b.ye;
    bus.mode = b.mode; bus.in_hs = b.hs; bus.in_vs = b.vs;
    bus.in_valid = 1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    check("accepted", acc, 1);
  endtask

  task automatic runOne(input beatT b, input logic [23:0] want, input string tag);
    int lat;
    bus.out_ready = 1;
    sendBeat(b);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_dout"}, bus.dout, want);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.out_ready = 1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    beatT b;
    logic [25:0] e;
    if (rst) begin
      q.delete();
      stallPrev = 0;
    end else begin
      if (stallPrev) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", {bus.out_hs, bus.out_vs, bus.dout}, prevOut);
      end
      check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        e = (q.size() != 0) ? q.pop_front() : 26'h3ffffff;
        check("out_beat", {bus.out_hs, bus.out_vs, bus.dout}, e);
        nOut++;
      end
      if (bus.in_valid && bus.in_ready) begin
        b.d00 = bus.d00; b.d01 = bus.d01; b.d10 = bus.d10; b.d11 = bus.d11;
        b.u = bus.uF; b.v = bus.vF; b.xe = bus.x_edge; b.ye = bus.y_edge;
        b.mode = bus.mode; b.hs = bus.in_hs; b.vs = bus.in_vs;
        q.push_back(model(b));
      end
      stallPrev = bus.out_valid && !bus.out_ready;
      prevOut = {bus.out_hs, bus.out_vs, bus.dout};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beatT b;
    logic [25:0] m;
    int n0;
    bus.in_valid = 0; bus.out_ready = 1;
    bus.d00 = '0; bus.d01 = '0; bus.d10 = '0; bus.d11 = '0;
    bus.uF = '0; bus.vF = '0; bus.x_edge = 0; bus.y_edge = 0;
    bus.mode = 0; bus.in_hs = 0; bus.in_vs = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_sideband", {bus.out_hs, bus.out_vs}, 0);
    rst = 0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    b = mk(24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000, 32, 0, 0, 0, 0);
    b.hs = 1; b.vs = 0;
    runOne(b, 24'h808080, "halfway");
    runOne(mk(24'h123456, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 0, 0), 24'h123456, "corner");
    runOne(mk(24'h000000, 24'h404040, 24'h808080, 24'hC0C0C0, 16, 48, 0, 0, 0), 24'h707070, "blend2d");
    runOne(mk(24'h111111, 24'h222222, 24'h333333, 24'h444444, 40, 10, 0, 0, 1), 24'h222222, "nearest_d01");
    runOne(mk(24'h111111, 24'h222222, 24'h333333, 24'h444444, 31, 32, 0, 0, 1), 24'h333333, "nearest_d10");
    runOne(mk(24'h0A0A0A, 24'hC8C8C8, 24'hC8C8C8, 24'hC8C8C8, 63, 0, 1, 0, 0), 24'h0A0A0A, "x_edge");
    runOne(mk(24'h0A0A0A, 24'h0A0A0A, 24'hFAFAFA, 24'hFAFAFA, 0, 63, 0, 1, 0), 24'h0A0A0A, "y_edge");
    runOne(mk(24'h0A0A0A, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 63, 63, 1, 1, 0), 24'h0A0A0A, "both_edges");

    n0 = nOut;
    fork
      for (int i = 0; i < 8; i++) sendBeat(rndBeat());
      begin
        for (int i = 0; i < 50 && !bus.out_valid; i++) begin
          @(posedge clk);
          #1;
        end
        check("bp_seen_valid", bus.out_valid, 1);
        bus.out_ready = 0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1;
      end
    join
    drain();
    check("bp_count", nOut - n0, 8);

    n0 = nOut;
    stopRnd = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          sendBeat(rndBeat());
        end
        stopRnd = 1;
      end
      while (!stopRnd) begin
        @(posedge clk);
        #1;
        bus.out_ready = $urandom_range(0, 3) != 0;
      end
    join
    drain();
    check("rnd_count", nOut - n0, 300);

    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) sendBeat(rndBeat());
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_dout", bus.dout, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_stale", bus.out_valid, 0);
    end
    b = rndBeat();
    m = model(b);
    runOne(b, m[23:0], "after_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
